// File: rtl/cmp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: FSM state
// encoding and the one-hot {gt,eq,lt} result codes.
package cmp_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [2:0] RES_GT = 3'b100;
   localparam logic [2:0] RES_EQ = 3'b010;
   localparam logic [2:0] RES_LT = 3'b001;

endpackage

// File: rtl/bit_cmp_cell.sv
// One bit-pair decision cell: flags a difference and tells whether operand A
// is the larger, honouring the inverted weight of a two's-complement sign bit.
module bit_cmp_cell (
   input  logic a,
   input  logic b,
   input  logic msb_signed,
   output logic differ,
   output logic a_wins
);

   // On a signed sign bit a set bit marks the negative (smaller) operand,
   // so the winning bit value flips.
   assign differ = a ^ b;
   assign a_wins = differ & (a ^ msb_signed);

endmodule

// File: rtl/serial_magnitude_compare.sv
// Bit-serial MSB-first magnitude comparator with start/busy/done handshake;
// unsigned or two's-complement per operation, results held until the next one.
module serial_magnitude_compare
   import cmp_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic [CNT_W-1:0] bits_used
);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic             rs;
   logic [CNT_W-1:0] cnt;
   logic             load;
   logic             decide;
   logic             equal;
   logic             last;
   logic             msb_signed;
   logic             differ;
   logic             a_wins;

   // The operands shift left each SHIFT cycle, so the bit under test is
   // always the top bit; cnt doubles as the bit index (0 = sign bit).
   assign last       = (cnt == CNT_W'(WIDTH - 1));
   assign msb_signed = rs & (cnt == '0);

   bit_cmp_cell u_cell (
      .a          (ra[WIDTH-1]),
      .b          (rb[WIDTH-1]),
      .msb_signed (msb_signed),
      .differ     (differ),
      .a_wins     (a_wins)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      decide     = 1'b0;
      equal      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (differ) begin
               decide     = 1'b1;
               state_next = S_DONE;
            end else if (last) begin
               equal      = 1'b1;
               state_next = S_DONE;
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Results load on the edge entering DONE so they are valid alongside done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ra        <= '0;
         rb        <= '0;
         rs        <= 1'b0;
         cnt       <= '0;
         gt        <= 1'b0;
         eq        <= 1'b0;
         lt        <= 1'b0;
         bits_used <= '0;
      end else begin
         if (load) begin
            ra  <= a;
            rb  <= b;
            rs  <= is_signed;
            cnt <= '0;
         end else if (state == S_SHIFT) begin
            ra  <= ra << 1;
            rb  <= rb << 1;
            cnt <= cnt + 1'b1;
         end
         if (decide) begin
            {gt, eq, lt} <= a_wins ? RES_GT : RES_LT;
            bits_used    <= cnt + 1'b1;
         end else if (equal) begin
            {gt, eq, lt} <= RES_EQ;
            bits_used    <= CNT_W'(WIDTH);
         end
      end
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_magnitude_compare.sv
// Self-checking bench: directed and random compares on WIDTH=8 and WIDTH=1
// instances, checked against an arithmetic reference model.
module tb_serial_magnitude_compare;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       s8 = 1'b0;
   logic       busy8, done8, gt8, eq8, lt8;
   logic [3:0] bits8;
   logic       start1 = 1'b0;
   logic [0:0] a1 = '0;
   logic [0:0] b1 = '0;
   logic       s1 = 1'b0;
   logic       busy1, done1, gt1, eq1, lt1;
   logic [0:0] bits1;

   int checks = 0;
   int errors = 0;
   bit sel1 = 1'b0;

   logic       o_busy, o_done;
   logic [2:0] o_res;
   logic [3:0] o_bits;

   assign o_busy = sel1 ? busy1 : busy8;
   assign o_done = sel1 ? done1 : done8;
   assign o_res  = sel1 ? {gt1, eq1, lt1} : {gt8, eq8, lt8};
   assign o_bits = sel1 ? {3'b000, bits1} : bits8;

   always #5 clk = ~clk;

   serial_magnitude_compare #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .is_signed(s8),
      .busy(busy8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8), .bits_used(bits8)
   );

   serial_magnitude_compare #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .is_signed(s1),
      .busy(busy1), .done(done1), .gt(gt1), .eq(eq1), .lt(lt1), .bits_used(bits1)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: numeric compare of the operands as integers, and the count of
   // bit pairs up to and including the most significant differing one.
   function automatic void model(input int w, input logic [31:0] x, input logic [31:0] y,
                                 input logic s, output logic [2:0] res, output int used);
      longint xv, yv;
      logic [31:0] diff;
      xv = longint'(x);
      yv = longint'(y);
      if (s && x[w-1]) xv = xv - (longint'(1) << w);
      if (s && y[w-1]) yv = yv - (longint'(1) << w);
      res  = (xv > yv) ? 3'b100 : ((xv < yv) ? 3'b001 : 3'b010);
      diff = x ^ y;
      used = w;
      for (int i = 0; i < w; i++) begin
         if (diff[i]) used = w - i;
      end
   endfunction

   // Entered and left on a falling edge; start is driven immediately so a
   // following call launches in the first IDLE cycle after done.
   task automatic applyStimulus(input bit one, input logic [7:0] ta, input logic [7:0] tb,
                                input logic ts, input bit inject);
      logic [2:0] exp_res;
      int         exp_used;
      int         w;
      int         lat;
      int         extra;
      w    = one ? 1 : 8;
      sel1 = one;
      model(w, one ? {31'd0, ta[0]} : {24'd0, ta}, one ? {31'd0, tb[0]} : {24'd0, tb},
            ts, exp_res, exp_used);
      if (one) begin
         a1 = ta[0]; b1 = tb[0]; s1 = ts; start1 = 1'b1;
      end else begin
         a8 = ta; b8 = tb; s8 = ts; start8 = 1'b1;
      end
      @(negedge clk);
      start1 = 1'b0;
      start8 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      s8 = 1'($urandom);
      lat = 1;
      checkOutput("busy_in_shift", 32'(o_busy), 32'd1);
      if (inject && !one) begin
         a8 = 8'hFF; b8 = 8'h00; s8 = 1'b0; start8 = 1'b1;
      end
      while (o_done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         start8 = 1'b0;
         lat++;
      end
      checkOutput("done_latency", 32'(lat), 32'(exp_used + 1));
      checkOutput("result", 32'(o_res), 32'(exp_res));
      checkOutput("bits_used", 32'(o_bits), 32'(exp_used));
      @(negedge clk);
      checkOutput("done_one_cycle", 32'(o_done), 32'd0);
      checkOutput("busy_after_done", 32'(o_busy), 32'd0);
      if (inject) begin
         extra = 0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o_done === 1'b1) extra++;
         end
         checkOutput("extra_done_pulses", 32'(extra), 32'd0);
         checkOutput("result_held", 32'(o_res), 32'(exp_res));
         checkOutput("bits_held", 32'(o_bits), 32'(exp_used));
      end
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      #1;
      checkOutput("reset_busy8", 32'(busy8), 32'd0);
      checkOutput("reset_done8", 32'(done8), 32'd0);
      checkOutput("reset_res8", 32'({gt8, eq8, lt8}), 32'd0);
      checkOutput("reset_bits8", 32'(bits8), 32'd0);
      checkOutput("reset_res1", 32'({gt1, eq1, lt1, bits1}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus(1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h80, 8'h7F, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h80, 8'h7F, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'hFE, 8'hFD, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h12, 8'h13, 1'b0, 1'b1);

      // Abort mid-SHIFT: everything, including the held result, clears at once.
      a8 = 8'h01; b8 = 8'h01; s8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 32'(busy8), 32'd0);
      checkOutput("abort_done", 32'(done8), 32'd0);
      checkOutput("abort_res", 32'({gt8, eq8, lt8}), 32'd0);
      checkOutput("abort_bits", 32'(bits8), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(1'b0, 8'h02, 8'h01, 1'b0, 1'b0);

      applyStimulus(1'b1, 8'h01, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h01, 8'h00, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      end

      // Random pairs, half of them differing in a single random bit so the
      // full range of decision depths is exercised.
      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom);
         rb = (i % 2 == 0) ? (ra ^ (8'd1 << $urandom_range(7, 0))) : 8'($urandom);
         applyStimulus(1'b0, ra, rb, 1'($urandom), (i % 10 == 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
